// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix line encoder: switch code values and FSM states.
package matrix_pkg;

    localparam int unsigned VEC_W  = 8;
    localparam int unsigned CODE_W = 3;

    localparam logic [CODE_W-1:0] CODE_L0      = 3'b110;
    localparam logic [CODE_W-1:0] CODE_L1      = 3'b100;
    localparam logic [CODE_W-1:0] CODE_L2      = 3'b101;
    localparam logic [CODE_W-1:0] CODE_L3      = 3'b010;
    localparam logic [CODE_W-1:0] CODE_L4      = 3'b011;
    localparam logic [CODE_W-1:0] CODE_L5      = 3'b001;
    localparam logic [CODE_W-1:0] CODE_L6      = 3'b000;
    localparam logic [CODE_W-1:0] CODE_DISPLAY = 3'b111;

    typedef enum logic {
        IDLE    = 1'b0,
        PUBLISH = 1'b1
    } enc_state_t;

endpackage

// File: rtl/line_debounce.sv
// Two-flop synchroniser plus hold-time debounce; pulses o_stable_c once per newly settled vector.
module line_debounce
    import matrix_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [VEC_W-1:0] i_vec,
    output logic [VEC_W-1:0] o_vec,
    output logic             o_stable_c
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEB_CYCLES - 1);

    logic [VEC_W-1:0] r_sync1;
    logic [VEC_W-1:0] r_sync2;
    logic [VEC_W-1:0] r_prev;
    logic [CNT_W-1:0] r_cnt;
    logic             w_same;

    assign w_same = (r_sync2 == r_prev);

    // Counter restarts on any change and saturates once the vector has settled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_vec;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_stable_c = w_same && (r_cnt == CNT_PRE);
    assign o_vec      = r_prev;

endmodule

// File: rtl/line_encoder.sv
// Encodes debounced one-hot panel lines into a 3-bit switch code delivered over valid/ready.
module line_encoder
    import matrix_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        lines_in,
    input  logic              display_in,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    input  logic              code_ready,
    output logic              err_multi,
    output logic              overrun,
    input  logic              err_clear
);

    logic [VEC_W-1:0]  w_vec;
    logic              w_stable;
    logic [CODE_W-1:0] w_code;
    logic              w_onehot;
    logic              w_zero;
    logic              w_multi;
    logic              w_hs;
    logic              w_new;

    enc_state_t        r_state;
    enc_state_t        w_state_nxt;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              r_ovr;
    logic              w_ovr_nxt;
    logic              r_last_vld;
    logic              w_last_vld_nxt;
    logic [CODE_W-1:0] r_last_code;
    logic [CODE_W-1:0] w_last_code_nxt;

    line_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_vec      ({display_in, lines_in}),
        .o_vec      (w_vec),
        .o_stable_c (w_stable)
    );

    // Line-to-code table; anything that is not exactly one bit is flagged non-one-hot.
    always_comb begin
        w_code   = CODE_L6;
        w_onehot = 1'b1;
        case (w_vec)
            8'h01:   w_code = CODE_L0;
            8'h02:   w_code = CODE_L1;
            8'h04:   w_code = CODE_L2;
            8'h08:   w_code = CODE_L3;
            8'h10:   w_code = CODE_L4;
            8'h20:   w_code = CODE_L5;
            8'h40:   w_code = CODE_L6;
            8'h80:   w_code = CODE_DISPLAY;
            default: w_onehot = 1'b0;
        endcase
    end

    assign w_zero  = (w_vec == '0);
    assign w_multi = !w_zero && !w_onehot;
    assign w_hs    = r_valid && code_ready;
    assign w_new   = w_stable && w_onehot && !(r_last_vld && (w_code == r_last_code));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_code      <= '0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_ovr       <= 1'b0;
            r_last_vld  <= 1'b0;
            r_last_code <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_valid     <= w_valid_nxt;
            r_err       <= w_err_nxt;
            r_ovr       <= w_ovr_nxt;
            r_last_vld  <= w_last_vld_nxt;
            r_last_code <= w_last_code_nxt;
        end
    end

    // Next-state logic; a flag being set in the same cycle as err_clear stays set.
    always_comb begin
        w_state_nxt     = r_state;
        w_code_nxt      = r_code;
        w_err_nxt       = r_err & ~err_clear;
        w_ovr_nxt       = r_ovr & ~err_clear;
        w_last_vld_nxt  = r_last_vld;
        w_last_code_nxt = r_last_code;

        if (w_stable && w_zero) begin
            w_last_vld_nxt = 1'b0;
        end
        if (w_stable && w_multi) begin
            w_err_nxt = 1'b1;
        end

        case (r_state)
            IDLE: begin
                if (w_new) begin
                    w_code_nxt      = w_code;
                    w_last_vld_nxt  = 1'b1;
                    w_last_code_nxt = w_code;
                    w_state_nxt     = PUBLISH;
                end
            end
            PUBLISH: begin
                if (w_new) begin
                    w_code_nxt      = w_code;
                    w_last_vld_nxt  = 1'b1;
                    w_last_code_nxt = w_code;
                    if (!w_hs) begin
                        w_ovr_nxt = 1'b1;
                    end
                end else if (w_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_valid_nxt = (w_state_nxt == PUBLISH);
    end

    assign code_out   = r_code;
    assign code_valid = r_valid;
    assign err_multi  = r_err;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_line_encoder.sv
// Scoreboard bench for line_encoder with DEB_CYCLES=4 and directed panel-line stimulus.
module tb_line_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] lines_in = '0;
    logic       display_in = 1'b0;
    logic [2:0] code_out;
    logic       code_valid;
    logic       code_ready = 1'b1;
    logic       err_multi;
    logic       overrun;
    logic       err_clear = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [2:0] exp_q[$];

    line_encoder #(
        .DEB_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lines_in   (lines_in),
        .display_in (display_in),
        .code_out   (code_out),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .err_multi  (err_multi),
        .overrun    (overrun),
        .err_clear  (err_clear)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles from t0 to the first negedge with code_valid high, or -1 on timeout.
    task automatic wait_valid(input int t0, input int budget, output int lat);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (code_valid) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic wait_code(input logic [2:0] c, input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (code_out == c) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic quiet(input int n, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (code_valid) bad++;
        end
        chk(nm, bad, 0);
    endtask

    // Monitor: every accepted code must match the oldest expected code.
    always @(negedge clk) begin
        if (rst_n && code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_code", int'(code_out), -1);
            end else begin
                chk("sb_code", int'(code_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int lat;
        int ok;
        int bad;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_code", int'(code_out), 0);
        chk("rst_valid", int'(code_valid), 0);
        chk("rst_err", int'(err_multi), 0);
        chk("rst_ovr", int'(overrun), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Idle inputs: nothing should ever be published.
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (code_valid || code_out != 3'b000) bad++;
        end
        chk("idle_100", bad, 0);

        // l4 press, latency and single-cycle valid with ready high.
        tick();
        exp_q.push_back(3'b011);
        lines_in = 7'b0010000;
        t0 = cyc;
        wait_valid(t0, 30, lat);
        chk("l4_latency", lat, 7);
        chk("l4_code", int'(code_out), 3'b011);
        @(negedge clk);
        chk("l4_valid_1cyc", int'(code_valid), 0);
        tick();
        lines_in = '0;
        quiet(12, "l4_release_quiet");

        // Same line again after release publishes again.
        tick();
        exp_q.push_back(3'b011);
        lines_in = 7'b0010000;
        t0 = cyc;
        wait_valid(t0, 30, lat);
        chk("l4_again_latency", lat, 7);
        tick();
        lines_in = '0;
        quiet(12, "l4_again_release_quiet");

        // Bouncing Display line must not publish until it holds.
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); display_in = 1'b1; if (code_valid) bad++;
            tick(); if (code_valid) bad++;
            tick(); display_in = 1'b0; if (code_valid) bad++;
            tick(); if (code_valid) bad++;
        end
        chk("bounce_quiet", bad, 0);
        exp_q.push_back(3'b111);
        tick();
        display_in = 1'b1;
        t0 = cyc;
        wait_valid(t0, 30, lat);
        chk("disp_seen", int'(lat >= 0), 1);
        chk("disp_code", int'(code_out), 3'b111);
        quiet(20, "disp_single_publish");
        tick();
        display_in = 1'b0;
        quiet(10, "disp_release_quiet");

        // Two lines at once: error, no publish, code held.
        tick();
        lines_in = 7'b0000011;
        quiet(15, "multi_no_publish");
        chk("multi_err", int'(err_multi), 1);
        chk("multi_code_held", int'(code_out), 3'b111);
        tick(); err_clear = 1'b1;
        tick(); err_clear = 1'b0;
        @(negedge clk);
        chk("multi_err_cleared", int'(err_multi), 0);
        tick();
        lines_in = '0;
        quiet(10, "multi_release_quiet");

        // Overrun: l0 unconsumed, then l5 replaces it.
        tick();
        code_ready = 1'b0;
        lines_in = 7'b0000001;
        t0 = cyc;
        wait_valid(t0, 30, lat);
        chk("l0_latency", lat, 7);
        chk("l0_code", int'(code_out), 3'b110);
        tick();
        exp_q.push_back(3'b001);
        lines_in = 7'b0100000;
        wait_code(3'b001, 30, ok);
        chk("l5_replaced", ok, 1);
        chk("l5_overrun", int'(overrun), 1);
        chk("l5_valid_held", int'(code_valid), 1);
        tick();
        code_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("l5_valid_dropped", int'(code_valid), 0);
        chk("ovr_sticky", int'(overrun), 1);
        tick(); err_clear = 1'b1;
        tick(); err_clear = 1'b0;
        @(negedge clk);
        chk("ovr_cleared", int'(overrun), 0);
        tick();
        lines_in = '0;
        quiet(10, "l5_release_quiet");

        // Asynchronous reset while a code is pending.
        tick();
        code_ready = 1'b0;
        lines_in = 7'b0000100;
        t0 = cyc;
        wait_valid(t0, 30, lat);
        chk("l2_code", int'(code_out), 3'b101);
        tick();
        lines_in = 7'b0000010;
        wait_code(3'b100, 30, ok);
        chk("l1_overrun", int'(overrun), 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_code", int'(code_out), 0);
        chk("arst_valid", int'(code_valid), 0);
        chk("arst_ovr", int'(overrun), 0);
        chk("arst_err", int'(err_multi), 0);
        lines_in = '0;
        code_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        quiet(20, "post_reset_quiet");

        chk("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
